trace_reader: RTL and testbench
===============================

// Module: trace_reader
// PURPOSE
//  Console-side drainer for the KS10 instruction trace stack. Pops PC/IR
//  records newest-first by pulsing trADV and decoding the 64-bit trITR word.
//  Emits one record per valid/ready handshake toward the console/host link.
//  Sits between the trace stack status word and the host readout path; also
//  issues the trace clear.
// PARAMETERS
//  ADV_WIDTH  1   trADV high time in clocks, 1..15
//  SETTLE     2   clocks after trADV falls before trITR is sampled (pop+LIFO read), 1..15
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset: synchronous, active-high
//  start      in   1   begin drain (accepted in IDLE only)
//  abort      in   1   stop drain, return to IDLE
//  clear      in   1   request trace clear (accepted in IDLE only)
//  limit      in   13  max records to deliver; 0 = until empty
//  trITR      in   64  [0:63]: b1 full, b2 empty, b3:7 log2size, b10:27 PC, b28:63 IR
//  trADV      out  1   advance (pop on falling edge)
//  trCLR      out  1   one-clock clear pulse
//  rec_valid  out  1   record available
//  rec_ready  in   1   downstream accept
//  rec_pc     out  18  PC of record
//  rec_ir     out  36  IR of record
//  rec_last   out  1   record is final under a nonzero limit
//  busy       out  1   not IDLE
//  done       out  1   one-clock pulse at drain completion
//  wrapped    out  1   full flag seen at first sample of the drain
//  depth_log2 out  5   log2size captured at first sample of the drain
//  rec_cnt    out  13  records delivered this drain
// BEHAVIOUR
//  Reset: every output 0; FSM to IDLE; counters 0.
//  FSM states:
//   IDLE:   start -> WAIT, clears rec_cnt/wrapped; start+clear together: clear wins.
//           clear -> trCLR=1 for exactly 1 clock; stays IDLE.
//   WAIT:   SETTLE clocks -> CHECK.
//   CHECK:  sample trITR. First CHECK of a drain latches wrapped=b1, depth_log2=b3:7.
//           empty(b2)=1 -> DONE; else latch pc/ir -> OFFER.
//   OFFER:  rec_valid=1; pc/ir/last held stable until rec_valid&rec_ready.
//           On handshake: rec_cnt++ -> ADV.
//   ADV:    trADV=1 for ADV_WIDTH clocks -> SETTLE.
//   SETTLE: trADV=0; count SETTLE clocks, then go to CHECK,
//           or to DONE if limit!=0 and rec_cnt==limit.
//   DONE:   done=1 for 1 clock -> IDLE.
//  rec_last=1 in OFFER iff limit!=0 and rec_cnt==limit-1. An empty stop gives no rec_last.
//  limit is sampled at start; later changes are ignored.
//  Latency: start -> first rec_valid = SETTLE+2 clocks.
//           handshake -> next rec_valid = ADV_WIDTH+SETTLE+2 clocks.
//  abort (any non-IDLE state) -> IDLE next clock:
//   - rec_valid and trADV drop; no done pulse.
//   - Abort in ADV still pops, because trADV falls. That record was already delivered.
//   - Abort in OFFER pops nothing.
//  Handshake and abort in the same OFFER clock: abort wins; rec_cnt is not incremented.
//  rec_cnt saturates at 8191. A limit of 8191 with a 4K stack ends on empty.
//  rst mid-drain: immediate IDLE; trADV=0 (a pending pop may occur in the stack).
//  start/clear while busy: ignored.
// CONFIGURATION
//  TRACE_READER_FILTER_EN defined:
//   - Adds inputs pc_lo[18], pc_hi[18] and output skip_cnt[13].
//   - CHECK with PC outside [pc_lo,pc_hi] inclusive goes directly to ADV (popped, not offered).
//   - skip_cnt increments (saturating) on each skip. limit counts delivered records only.
//  Undefined: no filter ports; every non-empty sample is offered.
// TESTING
//  Push 3 records (PC 1000,1001,1002); start, limit=0, ready=1
//   -> PCs 1002,1001,1000 in order; done; rec_cnt=3; rec_last never set.
//  5 records; limit=2 -> 2 records delivered, second with rec_last=1; done; 3 remain in stack.
//  Empty stack; start -> no rec_valid; done pulse at clock SETTLE+2; rec_cnt=0.
//  Hold rec_ready=0 for 20 clocks in OFFER -> rec_valid/pc/ir stable, trADV stays 0.
//  Abort during OFFER -> IDLE, no pop; restart delivers the same record.
//  Fill 4K+1 (full) -> wrapped=1, depth_log2=12.
//  clear in IDLE -> trCLR high exactly 1 clock; next drain done with rec_cnt=0.
//  FILTER_EN: pc_lo=pc_hi=1001 on the 3-record set -> only 1001 delivered; skip_cnt=2.

Source files
------------

// File: rtl/trace_reader.sv
// ============================================================================
//  Module   : trace_reader
//  Purpose  : Drains the trace stack newest-first and hands each record to the
//             host over a valid/ready link. It also issues the trace clear.
//             Optional PC window filter: TRACE_READER_FILTER_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_reader #(
    parameter int ADV_WIDTH = 1,
    parameter int SETTLE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        clear,
    input  logic [12:0] limit,
    input  logic [0:63] trITR,
    output logic        trADV,
    output logic        trCLR,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [17:0] rec_pc,
    output logic [35:0] rec_ir,
    output logic        rec_last,
    output logic        busy,
    output logic        done,
    output logic        wrapped,
    output logic [4:0]  depth_log2,
    output logic [12:0] rec_cnt
`ifdef TRACE_READER_FILTER_EN
    ,
    input  logic [17:0] pc_lo,
    input  logic [17:0] pc_hi,
    output logic [12:0] skip_cnt
`endif
);

    localparam logic [2:0]  c_IDLE        = 3'd0;
    localparam logic [2:0]  c_WAIT        = 3'd1;
    localparam logic [2:0]  c_CHECK       = 3'd2;
    localparam logic [2:0]  c_OFFER       = 3'd3;
    localparam logic [2:0]  c_ADV         = 3'd4;
    localparam logic [2:0]  c_SETTLE      = 3'd5;
    localparam logic [2:0]  c_DONE        = 3'd6;
    localparam logic [3:0]  c_ADV_INIT    = 4'(ADV_WIDTH - 1);
    localparam logic [3:0]  c_SETTLE_INIT = 4'(SETTLE - 1);
    localparam logic [12:0] c_CNT_MAX     = 13'h1FFF;

    logic [2:0]  r_state;
    logic [3:0]  r_timer;
    logic [12:0] r_limit;
    logic        r_first;

    logic        w_full;
    logic        w_empty;
    logic [4:0]  w_log2;
    logic [17:0] w_pc;
    logic [35:0] w_ir;
    logic [2:0]  w_unused_bits;
    logic        w_skip;
    logic        w_accept;

    // trITR uses big-endian bit numbering: bit 0 is the MSB.
    assign w_full        = trITR[1];
    assign w_empty       = trITR[2];
    assign w_log2        = trITR[3:7];
    assign w_pc          = trITR[10:27];
    assign w_ir          = trITR[28:63];
    assign w_unused_bits = {trITR[0], trITR[8:9]};
    assign w_accept      = (r_state == c_IDLE) && start && !clear;

`ifdef TRACE_READER_FILTER_EN
    assign w_skip = (w_pc < pc_lo) || (w_pc > pc_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (w_accept) begin
            skip_cnt <= '0;
        end else if (r_state == c_CHECK && !abort && !w_empty && w_skip &&
                     skip_cnt != c_CNT_MAX) begin
            skip_cnt <= skip_cnt + 13'd1;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_timer    <= '0;
            r_limit    <= '0;
            r_first    <= 1'b0;
            trADV      <= 1'b0;
            trCLR      <= 1'b0;
            rec_valid  <= 1'b0;
            rec_pc     <= '0;
            rec_ir     <= '0;
            rec_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrapped    <= 1'b0;
            depth_log2 <= '0;
            rec_cnt    <= '0;
        end else begin
            trCLR <= 1'b0;
            done  <= 1'b0;
            if (abort && r_state != c_IDLE) begin
                // Dropping trADV here completes any pop already in flight.
                r_state   <= c_IDLE;
                busy      <= 1'b0;
                rec_valid <= 1'b0;
                rec_last  <= 1'b0;
                trADV     <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (clear) begin
                            trCLR <= 1'b1;
                        end else if (start) begin
                            r_state <= c_WAIT;
                            r_timer <= c_SETTLE_INIT;
                            r_limit <= limit;
                            r_first <= 1'b1;
                            busy    <= 1'b1;
                            rec_cnt <= '0;
                            wrapped <= 1'b0;
                        end
                    end
                    c_WAIT: begin
                        if (r_timer == 4'd0) r_state <= c_CHECK;
                        else                 r_timer <= r_timer - 4'd1;
                    end
                    c_CHECK: begin
                        r_first <= 1'b0;
                        if (r_first) begin
                            wrapped    <= w_full;
                            depth_log2 <= w_log2;
                        end
                        if (w_empty) begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                        end else if (w_skip) begin
                            r_state <= c_ADV;
                            r_timer <= c_ADV_INIT;
                            trADV   <= 1'b1;
                        end else begin
                            r_state   <= c_OFFER;
                            rec_valid <= 1'b1;
                            rec_pc    <= w_pc;
                            rec_ir    <= w_ir;
                            rec_last  <= (r_limit != 13'd0) &&
                                         (rec_cnt == r_limit - 13'd1);
                        end
                    end
                    c_OFFER: begin
                        if (rec_ready) begin
                            r_state   <= c_ADV;
                            r_timer   <= c_ADV_INIT;
                            trADV     <= 1'b1;
                            rec_valid <= 1'b0;
                            rec_last  <= 1'b0;
                            if (rec_cnt != c_CNT_MAX) rec_cnt <= rec_cnt + 13'd1;
                        end
                    end
                    c_ADV: begin
                        if (r_timer == 4'd0) begin
                            r_state <= c_SETTLE;
                            r_timer <= c_SETTLE_INIT;
                            trADV   <= 1'b0;
                        end else begin
                            r_timer <= r_timer - 4'd1;
                        end
                    end
                    c_SETTLE: begin
                        if (r_timer != 4'd0) begin
                            r_timer <= r_timer - 4'd1;
                        end else if (r_limit != 13'd0 && rec_cnt == r_limit) begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= c_CHECK;
                        end
                    end
                    c_DONE: begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trace_reader.sv
// ============================================================================
//  Module   : tb_trace_reader
//  Purpose  : Self-checking bench for trace_reader against a LIFO stack model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trace_reader;

    localparam int c_AW = 1;
    localparam int c_ST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        clear = 1'b0;
    logic [12:0] limit = '0;
    logic [0:63] trITR;
    logic        trADV, trCLR, rec_valid, rec_last, busy, done, wrapped;
    logic        rec_ready = 1'b1;
    logic [17:0] rec_pc;
    logic [35:0] rec_ir;
    logic [4:0]  depth_log2;
    logic [12:0] rec_cnt;
`ifdef TRACE_READER_FILTER_EN
    logic [17:0] pc_lo = '0;
    logic [17:0] pc_hi = 18'h3FFFF;
    logic [12:0] skip_cnt;
`endif

    always #5 clk = ~clk;

    trace_reader #(.ADV_WIDTH(c_AW), .SETTLE(c_ST)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .clear(clear),
        .limit(limit), .trITR(trITR), .trADV(trADV), .trCLR(trCLR),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc),
        .rec_ir(rec_ir), .rec_last(rec_last), .busy(busy), .done(done),
        .wrapped(wrapped), .depth_log2(depth_log2), .rec_cnt(rec_cnt)
`ifdef TRACE_READER_FILTER_EN
        , .pc_lo(pc_lo), .pc_hi(pc_hi), .skip_cnt(skip_cnt)
`endif
    );

    // Trace stack model: 4K entries, pops when trADV falls, empties on trCLR.
    logic [17:0] pc_mem [0:4095];
    logic [35:0] ir_mem [0:4095];
    int          push_cnt = 0;
    int          pop_cnt = 0;
    int          sp;
    logic        full_f = 1'b0;
    logic        adv_q = 1'b0;
    int          done_cnt = 0;

    always_comb begin
        sp = push_cnt - pop_cnt;
        trITR = '0;
        trITR[1] = full_f;
        trITR[2] = (sp == 0);
        trITR[3:7] = 5'd12;
        if (sp > 0) begin
            trITR[10:27] = pc_mem[sp-1];
            trITR[28:63] = ir_mem[sp-1];
        end
    end

    always @(posedge clk) begin
        adv_q <= trADV;
        if (trCLR) pop_cnt <= push_cnt;
        else if (adv_q && !trADV && sp > 0) pop_cnt <= pop_cnt + 1;
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    int total = 0;
    int bad = 0;

    function automatic logic [35:0] mk_ir(input logic [17:0] pc);
        return {pc ^ 18'h2A5A5, ~pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic empty_stack;
        push_cnt = pop_cnt;
        full_f = 1'b0;
    endtask

    task automatic push(input logic [17:0] pc);
        int idx;
        idx = push_cnt - pop_cnt;
        if (idx >= 4096) begin
            full_f = 1'b1;
            pc_mem[4095] = pc;
            ir_mem[4095] = mk_ir(pc);
        end else begin
            pc_mem[idx] = pc;
            ir_mem[idx] = mk_ir(pc);
            push_cnt = push_cnt + 1;
        end
    endtask

    // Records were pushed as 1000, 1001, ... so the k-th delivered is 1000+n-1-k.
    task automatic run_drain(input logic [12:0] lim, input int n_push,
                             input int last_pos, output int got);
        bit fin;
        fin = 1'b0;
        got = 0;
        limit = lim;
        start = 1'b1;
        tick;
        start = 1'b0;
        limit = 13'd1;
        for (int c = 0; c < 500 && !fin; c++) begin
            if (rec_valid) begin
                chk("rec_pc", 64'(rec_pc), 64'(18'(1000 + n_push - 1 - got)));
                chk("rec_ir", 64'(rec_ir), 64'(mk_ir(18'(1000 + n_push - 1 - got))));
                chk("rec_last", 64'(rec_last), 64'(got == last_pos));
                got++;
            end
            if (done) fin = 1'b1;
            else tick;
        end
        chk("done_pulse", 64'(fin), 64'd1);
        tick;
        chk("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    typedef struct {
        int          n_push;
        logic [12:0] lim;
        int          exp_cnt;
        int          exp_left;
        int          last_pos;
    } vec_t;

    vec_t vecs [6];
    int   got;
    int   k;
    int   d0;
    logic [17:0] pc0;
    int   stall_err;

    initial begin
        vecs[0] = '{3, 13'd0, 3, 0, -1};
        vecs[1] = '{5, 13'd2, 2, 3, 1};
        vecs[2] = '{0, 13'd0, 0, 0, -1};
        vecs[3] = '{4, 13'd4, 4, 0, 3};
        vecs[4] = '{2, 13'd5, 2, 0, -1};
        vecs[5] = '{1, 13'd1, 1, 0, 0};

        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("reset_flags", 64'({trADV, trCLR, rec_valid, rec_last, busy, done, wrapped}), 64'd0);
        chk("reset_data", 64'({rec_pc, rec_cnt, depth_log2}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            empty_stack;
            for (int j = 0; j < vecs[i].n_push; j++) push(18'(1000 + j));
            run_drain(vecs[i].lim, vecs[i].n_push, vecs[i].last_pos, got);
            chk("rec_count", 64'(got), 64'(vecs[i].exp_cnt));
            chk("rec_cnt", 64'(rec_cnt), 64'(vecs[i].exp_cnt));
            chk("stack_left", 64'(sp), 64'(vecs[i].exp_left));
            chk("wrapped_clear", 64'(wrapped), 64'd0);
        end

        // Empty stack: done after SETTLE+2 edges, no record offered.
        empty_stack;
        limit = 13'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        k = 1;
        got = 0;
        while (!done && k < 50) begin
            if (rec_valid) got++;
            tick;
            k++;
        end
        chk("empty_done_lat", 64'(k), 64'(c_ST + 2));
        chk("empty_no_valid", 64'(got), 64'd0);
        tick;

        // Latency, stall, abort in OFFER, restart, abort in ADV.
        d0 = done_cnt;
        empty_stack;
        for (int j = 0; j < 3; j++) push(18'(1000 + j));
        rec_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        k = 1;
        while (!rec_valid && k < 50) begin tick; k++; end
        chk("first_lat", 64'(k), 64'(c_ST + 2));
        pc0 = rec_pc;
        chk("first_pc", 64'(pc0), 64'd1002);
        stall_err = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (!rec_valid || rec_pc !== pc0 || rec_ir !== mk_ir(pc0) || trADV) stall_err++;
        end
        chk("stall_stable", 64'(stall_err), 64'd0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_offer", 64'({busy, rec_valid, trADV}), 64'd0);
        tick; tick;
        chk("abort_offer_nopop", 64'(sp), 64'd3);
        chk("abort_offer_cnt", 64'(rec_cnt), 64'd0);

        rec_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        k = 1;
        while (!rec_valid && k < 50) begin tick; k++; end
        chk("restart_pc", 64'(rec_pc), 64'd1002);
        tick;
        k = 1;
        while (!rec_valid && k < 50) begin tick; k++; end
        chk("hs_lat", 64'(k), 64'(c_AW + c_ST + 2));
        chk("second_pc", 64'(rec_pc), 64'd1001);
        tick;
        chk("adv_high", 64'(trADV), 64'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_adv", 64'({busy, rec_valid, trADV}), 64'd0);
        tick; tick;
        chk("abort_adv_pop", 64'(sp), 64'd1);
        chk("abort_adv_cnt", 64'(rec_cnt), 64'd2);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Overfilled stack: wrapped and depth captured at the first sample.
        empty_stack;
        for (int j = 0; j < 4097; j++) push(18'(1000 + j));
        run_drain(13'd1, 4097, 0, got);
        chk("wrap_flag", 64'(wrapped), 64'd1);
        chk("wrap_depth", 64'(depth_log2), 64'd12);
        chk("wrap_cnt", 64'(rec_cnt), 64'd1);

        // Clear beats a simultaneous start; one-clock trCLR.
        clear = 1'b1;
        start = 1'b1;
        tick;
        clear = 1'b0;
        start = 1'b0;
        chk("clr_pulse", 64'({trCLR, busy}), 64'b10);
        tick;
        chk("clr_one_clk", 64'(trCLR), 64'd0);
        full_f = 1'b0;
        tick;
        chk("clr_emptied", 64'(sp), 64'd0);
        run_drain(13'd0, 0, -1, got);
        chk("clr_drain_cnt", 64'(rec_cnt), 64'd0);

`ifdef TRACE_READER_FILTER_EN
        empty_stack;
        for (int j = 0; j < 3; j++) push(18'(1000 + j));
        pc_lo = 18'd1001;
        pc_hi = 18'd1001;
        limit = 13'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        got = 0;
        k = 0;
        while (!done && k < 200) begin
            if (rec_valid) begin
                chk("filt_pc", 64'(rec_pc), 64'd1001);
                got++;
            end
            tick;
            k++;
        end
        chk("filt_done", 64'(done), 64'd1);
        chk("filt_got", 64'(got), 64'd1);
        chk("filt_skip", 64'(skip_cnt), 64'd2);
        chk("filt_cnt", 64'(rec_cnt), 64'd1);
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
